// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked RV32 execute unit with iterative RV-M engine
//
// Base ALU ops produce a registered result one cycle after acceptance. RV-M ops
// run through a shift-add multiplier / restoring divider, one bit per cycle
// (CALC), then a sign/selection fix-up cycle (FIX), giving XLEN+2 cycle latency.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   FLUSH             synchronous abort of in-flight op and held result
//   IN_VALID/IN_READY operand handshake
//   PC_IN, RS1_IN, RS2_IN, IMM_IN   operand sources
//   FUNCT3, FUNCT7, TYPES           decode inputs; TYPES one-hot {R,I,L,S,J,B,U}
//   OUT_VALID/OUT_READY result handshake, ALU_OUT result
//   BUSY              multiply/divide iteration in progress
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] PC_IN,
    input  logic [XLEN-1:0] RS1_IN,
    input  logic [XLEN-1:0] RS2_IN,
    input  logic [XLEN-1:0] IMM_IN,
    input  logic [2:0]      FUNCT3,
    input  logic [6:0]      FUNCT7,
    input  logic [6:0]      TYPES,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] ALU_OUT,
    output logic            BUSY
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t state, state_next;

    logic t_r, t_i, t_l, t_s, t_j, t_b, t_u;
    assign {t_r, t_i, t_l, t_s, t_j, t_b, t_u} = TYPES;

    logic [XLEN-1:0] bus_a, bus_b;
    logic [SHW-1:0]  shamt;
    logic [3:0]      op_sel;
    logic [XLEN-1:0] base_result;
    logic            m_op;
    logic            accept;

    logic            out_valid_q;
    logic [XLEN-1:0] alu_out_q;
    logic [CW-1:0]   cnt;

    // Multiply/divide working registers. acc holds {hi, lo}: for multiply
    // lo is the multiplier being shifted out and hi the running partial sum;
    // for divide lo is the dividend shifting into the partial remainder (hi)
    // while quotient bits shift in at the bottom.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m_opb;
    logic [XLEN-1:0]   m_dividend;
    logic [2:0]        m_f3;
    logic              m_neg;
    logic              m_neg_rem;
    logic              m_div_zero;
    logic              m_ovf;

    // Operand muxing: JALR (J|I) uses RS1, JAL/branch/AUIPC use PC.
    assign bus_a = ((t_j & ~t_i) | t_b | t_u) ? PC_IN : RS1_IN;
    assign bus_b = t_r ? RS2_IN : IMM_IN;
    assign shamt = bus_b[SHW-1:0];

    // I-type only honours FUNCT7[5] for the shift-right pair (SRLI/SRAI).
    always_comb begin
        op_sel = {FUNCT3, FUNCT7[5]};
        if (t_l | t_s | t_j | t_b | t_u)
            op_sel = 4'b0000;
        else if (t_i && FUNCT3 != 3'b101)
            op_sel = {FUNCT3, 1'b0};
    end

    always_comb begin
        base_result = '0;
        case (op_sel)
            4'b0000: base_result = bus_a + bus_b;
            4'b0001: base_result = bus_a - bus_b;
            4'b0010: base_result = bus_a << shamt;
            4'b0100: base_result = {{(XLEN-1){1'b0}}, ($signed(bus_a) < $signed(bus_b))};
            4'b0110: base_result = {{(XLEN-1){1'b0}}, (bus_a < bus_b)};
            4'b1000: base_result = bus_a ^ bus_b;
            4'b1010: base_result = bus_a >> shamt;
            4'b1011: base_result = $unsigned($signed(bus_a) >>> shamt);
            4'b1100: base_result = bus_a | bus_b;
            4'b1110: base_result = bus_a & bus_b;
            default: base_result = '0;
        endcase
    end

    assign m_op     = t_r && (FUNCT7 == 7'b0000001) && (ENABLE_M != 0);
    assign IN_READY = RST_N && (state == S_IDLE) && (!out_valid_q || OUT_READY) && !FLUSH;
    assign accept   = IN_VALID && IN_READY;

    assign OUT_VALID = out_valid_q;
    assign ALU_OUT   = alu_out_q;
    assign BUSY      = (state == S_CALC);

    // Operand signedness and magnitudes for the M engine, decoded at accept.
    logic            is_div, a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        is_div   = FUNCT3[2];
        a_signed = is_div ? ~FUNCT3[0] : (FUNCT3 == 3'b001 || FUNCT3 == 3'b010);
        b_signed = is_div ? ~FUNCT3[0] : (FUNCT3 == 3'b001);
        sa       = a_signed & bus_a[XLEN-1];
        sb       = b_signed & bus_b[XLEN-1];
        mag_a    = sa ? -bus_a : bus_a;
        mag_b    = sb ? -bus_b : bus_b;
    end

    // One iteration of shift-add multiply or restoring divide.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_opb} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_opb};
        if (m_f3[2]) begin
            if (!div_diff[XLEN])
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign correction and result selection for the FIX cycle.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = m_neg ? -acc : acc;
        quo_fix  = m_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = m_neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (m_f3)
            3'b000:                  fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:          fix_result = m_div_zero ? '1 :
                                                  m_ovf      ? m_dividend : quo_fix;
            default:                 fix_result = m_div_zero ? m_dividend :
                                                  m_ovf      ? '0 : rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && m_op) state_next = S_CALC;
            S_CALC:  if (cnt == '0) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (FLUSH)
            state_next = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            cnt         <= '0;
            acc         <= '0;
            m_opb       <= '0;
            m_dividend  <= '0;
            m_f3        <= '0;
            m_neg       <= 1'b0;
            m_neg_rem   <= 1'b0;
            m_div_zero  <= 1'b0;
            m_ovf       <= 1'b0;
        end else if (FLUSH) begin
            out_valid_q <= 1'b0;
            cnt         <= '0;
        end else begin
            if (out_valid_q && OUT_READY)
                out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (m_op) begin
                            cnt        <= CW'(XLEN-1);
                            m_f3       <= FUNCT3;
                            m_neg      <= sa ^ sb;
                            m_neg_rem  <= sa;
                            m_dividend <= bus_a;
                            m_div_zero <= is_div && (bus_b == '0);
                            m_ovf      <= is_div && !FUNCT3[0] && (bus_b == '1) &&
                                          (bus_a == {1'b1, {(XLEN-1){1'b0}}});
                            m_opb      <= is_div ? mag_b : mag_a;
                            acc        <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        end else begin
                            alu_out_q   <= base_result;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    alu_out_q   <= fix_result;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

    localparam logic [6:0] T_R = 7'b1000000;
    localparam logic [6:0] T_I = 7'b0100000;
    localparam logic [6:0] T_L = 7'b0010000;
    localparam logic [6:0] T_S = 7'b0001000;
    localparam logic [6:0] T_J = 7'b0000100;
    localparam logic [6:0] T_B = 7'b0000010;
    localparam logic [6:0] T_U = 7'b0000001;
    localparam logic [6:0] F7_M   = 7'b0000001;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] PC_IN, RS1_IN, RS2_IN, IMM_IN;
    logic [2:0]  FUNCT3;
    logic [6:0]  FUNCT7;
    logic [6:0]  TYPES;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] ALU_OUT;
    logic        BUSY;

    alu_exec_unit #(.XLEN(32), .ENABLE_M(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .PC_IN(PC_IN), .RS1_IN(RS1_IN), .RS2_IN(RS2_IN), .IMM_IN(IMM_IN),
        .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .TYPES(TYPES),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALU_OUT(ALU_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endfunction

    // Monitor: every transfer seen on the output pops one expected result.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got=%h exp=none", ALU_OUT);
            end else begin
                mon_e = sb_q.pop_front();
                chk(mon_e.name, ALU_OUT, mon_e.val);
            end
        end
    end

    task automatic send(input logic [6:0] t, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input bit push, input logic [31:0] ev,
                        input string nm, output int waited);
        TYPES = t; FUNCT3 = f3; FUNCT7 = f7;
        PC_IN = pc; RS1_IN = rs1; RS2_IN = rs2; IMM_IN = imm;
        IN_VALID = 1'b1;
        waited = 0;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            waited++;
            if (waited > 80) break;
        end
        if (!IN_READY) begin
            chk({nm, "_accept_timeout"}, 32'(waited), 32'd0);
            IN_VALID = 1'b0;
            return;
        end
        if (push) sb_q.push_back('{val: ev, name: nm});
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    // Returns the cycle (1 = cycle after acceptance) at which OUT_VALID shows.
    task automatic wait_result(output int lat);
        lat = 0;
        forever begin
            lat++;
            @(negedge CLK);
            if (OUT_VALID) break;
            if (lat > 80) break;
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic run_op(input logic [6:0] t, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] ev, input string nm,
                          input int exp_lat);
        int w, lat;
        send(t, f3, f7, pc, rs1, rs2, imm, 1'b1, ev, nm, w);
        wait_result(lat);
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int w, lat, valid_at, busy_first, busy_last, rdy_hi, vcount;

        RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        PC_IN = '0; RS1_IN = '0; RS2_IN = '0; IMM_IN = '0;
        FUNCT3 = '0; FUNCT7 = '0; TYPES = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", {31'b0, IN_READY}, 32'd0);
        chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_alu_out", ALU_OUT, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", {31'b0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        // Base ops, latency 1
        run_op(T_R, 3'b000, F7_ALT, 32'h0, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, "sub", 1);
        run_op(T_I, 3'b000, F7_ALT, 32'h0, 32'd5, 32'h0, 32'd7, 32'd12, "addi_not_sub", 1);
        run_op(T_R, 3'b010, 7'h00, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1, "slt", 1);
        run_op(T_R, 3'b011, 7'h00, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd0, "sltu", 1);
        run_op(T_R, 3'b100, 7'h00, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0, 32'hFF00, "xor", 1);
        run_op(T_R, 3'b110, 7'h00, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0, 32'hFFF0, "or", 1);
        run_op(T_R, 3'b111, 7'h00, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h00F0, "and", 1);
        run_op(T_R, 3'b001, 7'h00, 32'h0, 32'd1, 32'h23, 32'h0, 32'd8, "sll_shamt_mask", 1);
        run_op(T_R, 3'b101, 7'h00, 32'h0, 32'h80000000, 32'd31, 32'h0, 32'd1, "srl", 1);
        run_op(T_I, 3'b101, F7_ALT, 32'h0, 32'h80000000, 32'h0, 32'h404, 32'hF8000000, "srai", 1);
        run_op(T_R, 3'b010, F7_ALT, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd0, "undef_op", 1);
        run_op(T_J, 3'b000, 7'h00, 32'h100, 32'h5555, 32'h0, 32'd8, 32'h108, "jal", 1);
        run_op(T_J | T_I, 3'b000, 7'h00, 32'h100, 32'h300, 32'h0, 32'd4, 32'h304, "jalr", 1);
        run_op(T_U, 3'b000, 7'h00, 32'h1000, 32'h7777, 32'h0, 32'h12345000, 32'h12346000, "auipc", 1);
        run_op(T_L, 3'b010, F7_ALT, 32'h0, 32'h2000, 32'h0, 32'h10, 32'h2010, "load_addr", 1);

        // Back-to-back store then branch, one result per cycle
        send(T_S, 3'b010, 7'h00, 32'h0, 32'h1000, 32'h0, 32'hFFFFFFFC, 1'b1, 32'h00000FFC, "store_addr", w);
        send(T_B, 3'b000, 7'h00, 32'h200, 32'h0, 32'h0, 32'h10, 1'b1, 32'h210, "branch_tgt", w);
        chk("b2b_no_wait", 32'(w), 32'd0);
        wait_result(lat);
        chk("b2b_latency", 32'(lat), 32'd1);

        // MULH with timing profile
        send(T_R, 3'b001, F7_M, 32'h0, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 32'h40000000, "mulh", w);
        valid_at = -1; busy_first = -1; busy_last = -1; rdy_hi = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge CLK);
            if (BUSY) begin
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (OUT_VALID) valid_at = n;
            else if (IN_READY) rdy_hi++;
            @(posedge CLK); #1;
            if (valid_at >= 0) break;
        end
        chk("mulh_valid_cycle", 32'(valid_at), 32'd34);
        chk("mulh_busy_first", 32'(busy_first), 32'd1);
        chk("mulh_busy_last", 32'(busy_last), 32'd32);
        chk("mulh_in_ready_low", 32'(rdy_hi), 32'd0);

        run_op(T_R, 3'b000, F7_M, 32'h0, 32'd6, 32'd7, 32'h0, 32'd42, "mul", 34);
        run_op(T_R, 3'b010, F7_M, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFF, "mulhsu", 34);
        run_op(T_R, 3'b011, F7_M, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, "mulhu", 34);
        run_op(T_R, 3'b100, F7_M, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFD, "div_neg", 34);
        run_op(T_R, 3'b110, F7_M, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, "rem_neg", 34);
        run_op(T_R, 3'b100, F7_M, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf", 34);
        run_op(T_R, 3'b110, F7_M, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, "rem_ovf", 34);
        run_op(T_R, 3'b101, F7_M, 32'h0, 32'd9, 32'd0, 32'h0, 32'hFFFFFFFF, "divu_zero", 34);
        run_op(T_R, 3'b111, F7_M, 32'h0, 32'd9, 32'd0, 32'h0, 32'd9, "remu_zero", 34);
        run_op(T_R, 3'b100, F7_M, 32'h0, 32'hFFFFFFF9, 32'd0, 32'h0, 32'hFFFFFFFF, "div_zero", 34);
        run_op(T_R, 3'b110, F7_M, 32'h0, 32'hFFFFFFF9, 32'd0, 32'h0, 32'hFFFFFFF9, "rem_zero", 34);
        run_op(T_R, 3'b101, F7_M, 32'h0, 32'd100, 32'd7, 32'h0, 32'd14, "divu", 34);
        run_op(T_R, 3'b111, F7_M, 32'h0, 32'd100, 32'd7, 32'h0, 32'd2, "remu", 34);

        // Backpressure: result held while OUT_READY low
        OUT_READY = 1'b0;
        send(T_R, 3'b000, 7'h00, 32'h0, 32'd1, 32'd2, 32'h0, 1'b1, 32'd3, "stall_add", w);
        TYPES = T_R; FUNCT3 = 3'b100; FUNCT7 = 7'h00;
        RS1_IN = 32'hF0F0; RS2_IN = 32'h0FF0; IN_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("stall_out_valid", {31'b0, OUT_VALID}, 32'd1);
            chk("stall_alu_out", ALU_OUT, 32'd3);
            chk("stall_in_ready", {31'b0, IN_READY}, 32'd0);
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("release_in_ready", {31'b0, IN_READY}, 32'd1);
        if (IN_READY) sb_q.push_back('{val: 32'hFF00, name: "after_stall_xor"});
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        wait_result(lat);
        chk("after_stall_latency", 32'(lat), 32'd1);

        // FLUSH mid-divide, with a competing IN_VALID that must be refused
        send(T_R, 3'b100, F7_M, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 32'h0, "flush_div", w);
        repeat (8) begin @(posedge CLK); #1; end
        FLUSH = 1'b1;
        TYPES = T_R; FUNCT3 = 3'b000; FUNCT7 = 7'h00;
        RS1_IN = 32'd1; RS2_IN = 32'd1; IN_VALID = 1'b1;
        @(negedge CLK);
        chk("flush_in_ready", {31'b0, IN_READY}, 32'd0);
        chk("flush_busy_before", {31'b0, BUSY}, 32'd1);
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk("post_flush_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("post_flush_busy", {31'b0, BUSY}, 32'd0);
        chk("post_flush_out_valid", {31'b0, OUT_VALID}, 32'd0);
        vcount = 0;
        repeat (40) begin @(negedge CLK); if (OUT_VALID) vcount++; end
        chk("flush_no_result", 32'(vcount), 32'd0);
        @(posedge CLK); #1;

        // Reset mid-divide
        send(T_R, 3'b100, F7_M, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 32'h0, "rst_div", w);
        repeat (4) begin @(posedge CLK); #1; end
        RST_N = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, IN_READY}, 32'd0);
        chk("midrst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("midrst_busy", {31'b0, BUSY}, 32'd0);
        chk("midrst_alu_out", ALU_OUT, 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("midrst_release_ready", {31'b0, IN_READY}, 32'd1);
        vcount = 0;
        repeat (40) begin @(negedge CLK); if (OUT_VALID) vcount++; end
        chk("midrst_no_result", 32'(vcount), 32'd0);
        @(posedge CLK); #1;

        run_op(T_R, 3'b000, 7'h00, 32'h0, 32'd40, 32'd2, 32'h0, 32'd42, "add_after_rst", 1);

        repeat (3) @(posedge CLK);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
